// File: rtl/dma_hold_master_if.sv
// ============================================================================
// Module      : dma_hold_master_if
// Description : Bus-grant handshake and data-memory port shared between the
//               DMA copy engine (master) and the CPU/memory side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dma_hold_master_if #(
  parameter int wide = 32
);
  logic            hold;
  logic            holdACK;
  logic [31:0]     dm_a;
  logic [wide-1:0] dm_d;
  logic            dm_we;
  logic [wide-1:0] dm_q;

  modport master (
    output hold, dm_a, dm_d, dm_we,
    input  holdACK, dm_q
  );

  modport slave (
    input  hold, dm_a, dm_d, dm_we,
    output holdACK, dm_q
  );
endinterface

`default_nettype wire

// File: rtl/dma_hold_master.sv
// ============================================================================
// Module      : dma_hold_master
// Description : Memory-to-memory word copy engine. Requests the bus with
//               hold/holdACK, then copies LEN words from SRC to DST at one
//               word per two cycles, releases the bus and flags done/irq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_hold_master #(
  parameter int         wide   = 32,
  parameter logic [4:0] A_SRC  = 5'b11000,
  parameter logic [4:0] A_DST  = 5'b11001,
  parameter logic [4:0] A_LEN  = 5'b11010,
  parameter logic [4:0] A_CTRL = 5'b11011
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [4:0]           cfg_addr,
  input  logic [wide-1:0]      cfg_wd,
  output logic [wide-1:0]      cfg_rd,
  dma_hold_master_if.master    bus,
  output logic                 busy,
  output logic                 irq
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_REL   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_src;
  logic [31:0]     r_dst;
  logic [15:0]     r_len;
  logic [wide-1:0] r_buf;
  logic [31:0]     r_dm_a;
  logic            r_done;
  logic            r_irq_en;
  logic            r_irq;

  logic            w_hold;
  logic            w_dm_we;
  logic [31:0]     w_dm_a;
  logic            w_ctrl_we;
  logic            w_start;
  logic            w_done_nxt;
  logic            w_irq_en_nxt;

  assign busy      = (r_state != S_IDLE);
  assign w_ctrl_we = cfg_we && (cfg_addr == A_CTRL);
  // Start is only accepted from IDLE; a start written mid-copy is dropped.
  assign w_start   = w_ctrl_we && cfg_wd[0] && (r_state == S_IDLE);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, bus outputs, and done/irq_en update (set wins over clear).
  always_comb begin
    w_state_nxt  = r_state;
    w_hold       = 1'b0;
    w_dm_we      = 1'b0;
    w_dm_a       = r_dm_a;
    w_done_nxt   = r_done;
    w_irq_en_nxt = w_ctrl_we ? cfg_wd[2] : r_irq_en;

    if (w_ctrl_we && cfg_wd[1]) w_done_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (r_len != 16'd0) begin
            w_state_nxt = S_REQ;
            w_done_nxt  = 1'b0;
          end else begin
            // Zero-length copy completes without ever requesting the bus.
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_REQ: begin
        w_hold = 1'b1;
        if (bus.holdACK) w_state_nxt = S_READ;
      end
      S_READ: begin
        w_hold      = 1'b1;
        w_dm_a      = r_src;
        w_state_nxt = bus.holdACK ? S_WRITE : S_REQ;
      end
      S_WRITE: begin
        w_hold  = 1'b1;
        w_dm_a  = r_dst;
        // A grant dropped during the write cycle kills the strobe at once.
        w_dm_we = bus.holdACK;
        if (!bus.holdACK)          w_state_nxt = S_REQ;
        else if (r_len == 16'd1)   w_state_nxt = S_REL;
        else                       w_state_nxt = S_READ;
      end
      S_REL: begin
        if (!bus.holdACK) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Programmable registers, copy buffer, address/length progress and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src    <= 32'd0;
      r_dst    <= 32'd0;
      r_len    <= 16'd0;
      r_buf    <= '0;
      r_dm_a   <= 32'd0;
      r_done   <= 1'b0;
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_dm_a   <= w_dm_a;
      r_done   <= w_done_nxt;
      r_irq_en <= w_irq_en_nxt;
      r_irq    <= w_done_nxt & w_irq_en_nxt;

      if (cfg_we && !busy) begin
        if (cfg_addr == A_SRC) r_src <= {cfg_wd[31:2], 2'b00};
        if (cfg_addr == A_DST) r_dst <= {cfg_wd[31:2], 2'b00};
        if (cfg_addr == A_LEN) r_len <= cfg_wd[15:0];
      end

      if (r_state == S_READ && bus.holdACK) r_buf <= bus.dm_q;

      if (r_state == S_WRITE && bus.holdACK) begin
        r_src <= r_src + 32'd4;
        r_dst <= r_dst + 32'd4;
        r_len <= r_len - 16'd1;
      end
    end
  end

  // Register read mux; unmapped addresses return zero.
  always_comb begin
    cfg_rd = '0;
    case (cfg_addr)
      A_SRC:   cfg_rd = wide'(r_src);
      A_DST:   cfg_rd = wide'(r_dst);
      A_LEN:   cfg_rd = wide'(r_len);
      A_CTRL:  cfg_rd = wide'({r_irq_en, r_done, busy});
      default: cfg_rd = '0;
    endcase
  end

  assign bus.hold  = w_hold;
  assign bus.dm_we = w_dm_we;
  assign bus.dm_a  = w_dm_a;
  assign bus.dm_d  = r_buf;
  assign irq       = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_dma_hold_master.sv
// ============================================================================
// Module      : tb_dma_hold_master
// Description : Self-checking bench for dma_hold_master with a word-addressed
//               memory model and a write/hold monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_hold_master;

  localparam logic [4:0] A_SRC  = 5'b11000;
  localparam logic [4:0] A_DST  = 5'b11001;
  localparam logic [4:0] A_LEN  = 5'b11010;
  localparam logic [4:0] A_CTRL = 5'b11011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = 5'd0;
  logic [31:0] cfg_wd = 32'd0;
  logic [31:0] cfg_rd;
  logic        busy;
  logic        irq;

  logic        tie_ack = 1'b1;
  logic        man_ack = 1'b0;

  logic [31:0] mem [0:1023];
  logic [31:0] wlog [0:63];
  int          wcount = 0;
  int          hold_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  dma_hold_master_if #(.wide(32)) bus ();

  assign bus.holdACK = tie_ack ? bus.hold : man_ack;
  assign bus.dm_q    = mem[bus.dm_a[11:2]];

  dma_hold_master #(.wide(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wd   (cfg_wd),
    .cfg_rd   (cfg_rd),
    .bus      (bus),
    .busy     (busy),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Memory write port and monitor, sampled mid-cycle away from both edges.
  always @(negedge clk) begin
    #2;
    if (bus.dm_we) begin
      mem[bus.dm_a[11:2]] = bus.dm_d;
      wlog[wcount % 64]   = bus.dm_a;
      wcount++;
    end
    if (bus.hold) hold_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; the write lands on the next rising edge.
  task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_wd   = d;
    @(negedge clk);
    cfg_we   = 1'b0;
    cfg_wd   = 32'd0;
  endtask

  task automatic rd_reg(input logic [4:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rd;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wd;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [0:9];
  logic [31:0] d;
  int          w0;
  int          h0;
  int          n;

  initial begin
    vecs[0] = '{A_SRC,  32'h1234_5677, A_SRC,  32'h1234_5674};
    vecs[1] = '{A_DST,  32'hFFFF_FFFF, A_DST,  32'hFFFF_FFFC};
    vecs[2] = '{A_LEN,  32'h000A_BCDE, A_LEN,  32'h0000_BCDE};
    vecs[3] = '{A_CTRL, 32'h0000_0004, A_CTRL, 32'h0000_0004};
    vecs[4] = '{A_CTRL, 32'h0000_0000, A_CTRL, 32'h0000_0000};
    vecs[5] = '{A_SRC,  32'h0000_0003, A_SRC,  32'h0000_0000};
    vecs[6] = '{A_LEN,  32'h0000_0005, 5'h00,  32'h0000_0000};
    vecs[7] = '{A_DST,  32'h0000_0010, 5'h1C,  32'h0000_0000};
    vecs[8] = '{A_DST,  32'h0000_0010, A_DST,  32'h0000_0010};
    vecs[9] = '{A_LEN,  32'h0000_0000, A_LEN,  32'h0000_0000};

    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

    // Reset state with the clock running.
    repeat (2) @(negedge clk);
    chk("rst_hold",  {31'd0, bus.hold},  32'd0);
    chk("rst_dm_we", {31'd0, bus.dm_we}, 32'd0);
    chk("rst_dm_a",  bus.dm_a,           32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_irq",   {31'd0, irq},       32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    rd_reg(A_CTRL, d);
    chk("rst_status", d, 32'd0);

    // Register access vectors.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cfg_wr(vecs[i].waddr, vecs[i].wd);
      rd_reg(vecs[i].raddr, d);
      chk($sformatf("vec%0d", i), d, vecs[i].exp);
    end

    // Basic copy with immediate grant.
    mem[16] = 32'hA000_0001; mem[17] = 32'hA000_0002; mem[18] = 32'hA000_0003;
    @(negedge clk);
    cfg_wr(A_SRC, 32'h40);
    cfg_wr(A_DST, 32'h100);
    cfg_wr(A_LEN, 32'd3);
    w0 = wcount; h0 = hold_cnt;
    cfg_wr(A_CTRL, 32'h1);
    #1;
    chk("basic_hold_next", {31'd0, bus.hold}, 32'd1);
    chk("basic_busy",      {31'd0, busy},     32'd1);
    wait_idle("basic_timeout");
    @(negedge clk);
    chk("basic_wcount", wcount - w0, 32'd3);
    chk("basic_wa0", wlog[(w0 + 0) % 64], 32'h100);
    chk("basic_wa1", wlog[(w0 + 1) % 64], 32'h104);
    chk("basic_wa2", wlog[(w0 + 2) % 64], 32'h108);
    chk("basic_d0", mem[64], 32'hA000_0001);
    chk("basic_d1", mem[65], 32'hA000_0002);
    chk("basic_d2", mem[66], 32'hA000_0003);
    chk("basic_hold_cycles", hold_cnt - h0, 32'd7);
    rd_reg(A_CTRL, d); chk("basic_status", d, 32'h2);
    rd_reg(A_LEN, d);  chk("basic_len", d, 32'd0);
    rd_reg(A_SRC, d);  chk("basic_src", d, 32'h4C);
    rd_reg(A_DST, d);  chk("basic_dst", d, 32'h10C);

    // Zero length: done at the start edge, bus never requested.
    @(negedge clk);
    cfg_wr(A_CTRL, 32'h2);
    rd_reg(A_CTRL, d); chk("zl_cleared", d, 32'h0);
    @(negedge clk);
    cfg_wr(A_LEN, 32'd0);
    w0 = wcount; h0 = hold_cnt;
    cfg_wr(A_CTRL, 32'h1);
    rd_reg(A_CTRL, d); chk("zl_done", d, 32'h2);
    repeat (5) @(negedge clk);
    chk("zl_hold", hold_cnt - h0, 32'd0);
    chk("zl_we",   wcount - w0,   32'd0);

    // Grant loss during the first write.
    mem[32] = 32'hB000_0000; mem[33] = 32'hB000_0001;
    mem[192] = 32'd0; mem[193] = 32'd0;
    tie_ack = 1'b0; man_ack = 1'b0;
    cfg_wr(A_SRC, 32'h80);
    cfg_wr(A_DST, 32'h300);
    cfg_wr(A_LEN, 32'd2);
    w0 = wcount;
    cfg_wr(A_CTRL, 32'h1);
    #1 chk("gl_req_hold", {31'd0, bus.hold}, 32'd1);
    man_ack = 1'b1;
    @(negedge clk);
    #1;
    chk("gl_read_a",  bus.dm_a,           32'h80);
    chk("gl_read_we", {31'd0, bus.dm_we}, 32'd0);
    @(negedge clk);
    man_ack = 1'b0;
    mem[32] = 32'hB000_00FF;
    #1;
    chk("gl_write_a",   bus.dm_a,           32'h300);
    chk("gl_suppressed", {31'd0, bus.dm_we}, 32'd0);
    repeat (2) @(negedge clk);
    chk("gl_nowrite", wcount - w0, 32'd0);
    rd_reg(A_LEN, d); chk("gl_len_kept", d, 32'd2);
    rd_reg(A_SRC, d); chk("gl_src_kept", d, 32'h80);
    @(negedge clk);
    tie_ack = 1'b1;
    wait_idle("gl_timeout");
    @(negedge clk);
    chk("gl_wcount", wcount - w0, 32'd2);
    chk("gl_d0", mem[192], 32'hB000_00FF);
    chk("gl_d1", mem[193], 32'hB000_0001);

    // Busy lockout.
    cfg_wr(A_CTRL, 32'h2);
    cfg_wr(A_SRC, 32'h40);
    cfg_wr(A_DST, 32'h180);
    cfg_wr(A_LEN, 32'd3);
    w0 = wcount;
    cfg_wr(A_CTRL, 32'h1);
    cfg_wr(A_DST, 32'h200);
    cfg_wr(A_CTRL, 32'h1);
    cfg_wr(A_LEN, 32'd7);
    wait_idle("bl_timeout");
    @(negedge clk);
    chk("bl_wcount", wcount - w0, 32'd3);
    chk("bl_wa0", wlog[(w0 + 0) % 64], 32'h180);
    chk("bl_wa2", wlog[(w0 + 2) % 64], 32'h188);
    chk("bl_d2", mem[98], 32'hA000_0003);
    rd_reg(A_DST, d);  chk("bl_dst", d, 32'h18C);
    rd_reg(A_LEN, d);  chk("bl_len", d, 32'd0);
    rd_reg(A_CTRL, d); chk("bl_done", d, 32'h2);
    @(negedge clk);
    cfg_wr(A_CTRL, 32'h2);
    rd_reg(A_CTRL, d); chk("bl_clear", d, 32'h0);
    chk("bl_irq", {31'd0, irq}, 32'd0);

    // Interrupt, address wrap, and clear colliding with done-set.
    @(negedge clk);
    cfg_wr(A_CTRL, 32'h4);
    mem[1023] = 32'hC000_0000; mem[0] = 32'hC000_0001;
    mem[256] = 32'd0; mem[257] = 32'd0;
    cfg_wr(A_SRC, 32'hFFFF_FFFC);
    cfg_wr(A_DST, 32'h400);
    cfg_wr(A_LEN, 32'd2);
    cfg_wr(A_CTRL, 32'h5);
    rd_reg(A_CTRL, d); chk("wr_status_busy", d, 32'h5);
    chk("wr_irq_busy", {31'd0, irq}, 32'd0);
    n = 0;
    while (!(bus.hold == 1'b0 && busy == 1'b1) && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("wr_rel_found", {31'd0, (n < 50)}, 32'd1);
    cfg_we = 1'b1; cfg_addr = A_CTRL; cfg_wd = 32'h6;
    @(negedge clk);
    cfg_we = 1'b0; cfg_wd = 32'd0;
    rd_reg(A_CTRL, d); chk("wr_set_wins", d, 32'h6);
    chk("wr_irq", {31'd0, irq}, 32'd1);
    chk("wr_d0", mem[256], 32'hC000_0000);
    chk("wr_d1", mem[257], 32'hC000_0001);
    rd_reg(A_SRC, d); chk("wr_src_wrap", d, 32'h4);

    // Asynchronous reset in the middle of a copy.
    @(negedge clk);
    cfg_wr(A_SRC, 32'h40);
    cfg_wr(A_DST, 32'h500);
    cfg_wr(A_LEN, 32'd3);
    w0 = wcount;
    cfg_wr(A_CTRL, 32'h1);
    @(negedge clk);
    #1;
    chk("mr_pre_a", bus.dm_a, 32'h40);
    rst_n = 1'b0;
    #1;
    chk("mr_hold",  {31'd0, bus.hold},  32'd0);
    chk("mr_dm_we", {31'd0, bus.dm_we}, 32'd0);
    chk("mr_dm_a",  bus.dm_a,           32'd0);
    chk("mr_dm_d",  bus.dm_d,           32'd0);
    chk("mr_busy",  {31'd0, busy},      32'd0);
    chk("mr_irq",   {31'd0, irq},       32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rd_reg(A_CTRL, d); chk("mr_status", d, 32'd0);
    chk("mr_hold_after", {31'd0, bus.hold}, 32'd0);
    chk("mr_nowrite", wcount - w0, 32'd0);
    rd_reg(A_SRC, d); chk("mr_src", d, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dma_hold_master.md
Name: dma_hold_master

Overview:
- Memory-to-memory word copy engine. It is the initiator side of the CPU hold/holdACK bus-grant handshake.
- The CPU programs source, destination and length through a 5-bit register port.
- The engine then raises hold and waits for holdACK. While granted, it drives the data-memory port itself, copying one word every two cycles.
- When the copy finishes it releases the bus and flags completion, with an optional interrupt.

Parameters:
wide, 32, data word width of the memory port and registers
A_SRC, 5'b11000, register address of SRC
A_DST, 5'b11001, register address of DST
A_LEN, 5'b11010, register address of LEN
A_CTRL, 5'b11011, register address of CTRL/STATUS

Ports:
clk  in  1  system clock
rst  in  1  reset
cfg_we  in  1  register write strobe
cfg_addr  in  5  register select
cfg_wd  in  wide  register write data
cfg_rd  out  wide  register read data (combinational)
hold  out  1  bus request to the CPU
holdACK  in  1  bus grant from the CPU
dm_a  out  32  data-memory byte address
dm_d  out  wide  data-memory write data
dm_we  out  1  data-memory write enable
dm_q  in  wide  data-memory read data (combinational read)
busy  out  1  transfer in progress
irq  out  1  done & irq_en

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst=0) clears the following, immediately and independent of clk:
  - SRC, DST, LEN, data buffer, done, irq_en
  - outputs hold, dm_we, dm_a, dm_d, busy, irq all go to 0
  - state goes to IDLE
  - Reset mid-transfer abandons the copy; no further write is issued.
- Register writes on the rising edge when cfg_we=1:
  - SRC/DST: store cfg_wd with bits[1:0] forced to 0.
  - LEN: store cfg_wd[15:0] as a word count.
  - CTRL: bit0=start, bit1=clear done, bit2=irq_en.
  - SRC/DST/LEN writes while busy=1 are ignored. CTRL bits 1 and 2 are always honoured; bit0 while busy is ignored.
- Register reads (cfg_rd): SRC, DST, remaining LEN (zero-extended), or STATUS = {29'b0, irq_en, done, busy}. Any unmapped address reads 0.
- State machine: IDLE, REQ, READ, WRITE, REL.
  - IDLE: when start is written with LEN!=0, go to REQ, busy=1, and clear done. If LEN=0, set done at the same edge, stay in IDLE, and never raise hold.
  - REQ: hold=1. On the edge where holdACK=1, go to READ.
  - READ: dm_a=SRC, dm_we=0. Latch dm_q into the buffer at the edge, then go to WRITE.
  - WRITE: dm_a=DST, dm_d=buffer, dm_we=1 for exactly this cycle. At the edge: SRC+=4, DST+=4, LEN-=1. Then go to REL if the new LEN=0, else to READ.
  - REL: hold=0, dm_we=0. Once holdACK=0 is sampled, go to IDLE with busy=0 and done=1.
- Loss of grant: if holdACK=0 is sampled in READ or WRITE, that cycle's write is suppressed (dm_we forced 0 combinationally) and the state returns to REQ. SRC/DST/LEN are unchanged, so the same word is re-read when the grant returns.
- Outside READ/WRITE: dm_we=0 and dm_a holds its last value.
- Address arithmetic is 32-bit modulo 2^32; 0xFFFFFFFC+4 wraps to 0.
- Writes to 0x7000 are issued normally; the memory discards them and that is not the engine's concern.
- Latency with immediate grant: start edge → hold high next cycle. L words take 1 + 2L cycles from hold rising to hold falling. done is set on the first edge that samples holdACK=0 in REL.
- done is sticky until CTRL bit1 is written or reset. If a clear and the done-set occur at the same edge, the set wins.
- irq = done & irq_en, registered together with done.

Test Plan:
- Reset: hold rst=0 mid-stream with clk running → all outputs 0 at once; after release STATUS=0 and hold=0.
- Basic copy: SRC=0x40, DST=0x100, LEN=3, start, holdACK tied to hold → exactly 3 dm_we pulses at 0x100/0x104/0x108 with the data from 0x40/0x44/0x48; hold high for 7 cycles; done=1; LEN reads 0; SRC=0x4C.
- Zero length: LEN=0, start → done=1 at the same edge; hold never asserts; no dm_we.
- Grant loss: LEN=2, drop holdACK for 3 cycles during the first WRITE → that write is suppressed, the word is re-read after re-grant, exactly 2 committed writes occur, and the destination contents are correct.
- Busy lockout: write DST=0x200 and start during a transfer → DST and progress unaffected; after done, clear with CTRL=0x2 → done=0, irq=0.
- Interrupt/wrap: irq_en=1, SRC=0xFFFFFFFC, LEN=2 → second read at 0x0; irq=1 at done; a simultaneous clear and done-set leaves done=1.
